// File: rtl/bcd_scan_display.sv
// bcd_scan_display
// Time-multiplexed seven-segment driver for a 3-digit packed BCD value on a
// 4-digit common-anode display. New values are held in a pending register
// and copied to the displayed register only at a frame boundary, so a frame
// never mixes digits from two different values.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bcd_in     packed BCD {hundreds, tens, ones}
//   bcd_valid  load strobe, sampled every cycle
//   blank_lz   leading-zero blanking enable, sampled live
//   an         digit enables (an[0] ones .. an[2] hundreds, an[3] unused)
//   seg        segments {g,f,e,d,c,b,a}
//   dp         decimal point, always inactive
//   loaded     one-cycle pulse when the displayed value changes register
module bcd_scan_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        loaded
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] AN_OFF  = {4{ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [11:0]   r_disp;
  logic [11:0]   r_pend_val;
  logic          r_pend_flag;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_loaded;

  logic          w_tick;
  logic          w_boundary;
  logic          w_hund_blank;
  logic          w_tens_blank;
  logic          w_dark;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg_dec;
  logic [3:0]    w_an_ah;

  assign w_tick     = (r_cnt == CNT_MAX);
  assign w_boundary = w_tick && (r_idx == 2'd3);

  // Blanking ripples from the most significant digit downward; a dash
  // nibble is non-zero and therefore stops the ripple.
  assign w_hund_blank = blank_lz && (r_disp[11:8] == 4'd0);
  assign w_tens_blank = w_hund_blank && (r_disp[7:4] == 4'd0);

  always_comb begin
    w_nib  = r_disp[3:0];
    w_dark = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib  = r_disp[3:0];
        w_dark = 1'b0;
      end
      2'd1: begin
        w_nib  = r_disp[7:4];
        w_dark = w_tens_blank;
      end
      2'd2: begin
        w_nib  = r_disp[11:8];
        w_dark = w_hund_blank;
      end
      default: begin
        w_nib  = 4'd0;
        w_dark = 1'b1;
      end
    endcase
  end

  // Active-high segment decode, gfedcba.
  always_comb begin
    w_seg_dec = 7'h40;
    case (w_nib)
      4'd0:    w_seg_dec = 7'h3F;
      4'd1:    w_seg_dec = 7'h06;
      4'd2:    w_seg_dec = 7'h5B;
      4'd3:    w_seg_dec = 7'h4F;
      4'd4:    w_seg_dec = 7'h66;
      4'd5:    w_seg_dec = 7'h6D;
      4'd6:    w_seg_dec = 7'h7D;
      4'd7:    w_seg_dec = 7'h07;
      4'd8:    w_seg_dec = 7'h7F;
      4'd9:    w_seg_dec = 7'h6F;
      default: w_seg_dec = 7'h40;  // non-BCD nibble shows a dash
    endcase
  end

  // One-hot digit enable in active-high form; a dark slot enables nothing.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign w_an_ah[gi] = (r_idx == 2'(gi)) && !w_dark;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_disp      <= 12'h000;
      r_pend_val  <= 12'h000;
      r_pend_flag <= 1'b0;
      r_an        <= AN_OFF;
      r_seg       <= SEG_OFF;
      r_dp        <= ACTIVE_LOW;
      r_loaded    <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end

      if (w_boundary) begin
        // A strobe on the boundary cycle bypasses the pending register.
        if (bcd_valid) begin
          r_disp <= bcd_in;
        end else if (r_pend_flag) begin
          r_disp <= r_pend_val;
        end
        r_pend_flag <= 1'b0;
        r_loaded    <= bcd_valid || r_pend_flag;
      end else begin
        if (bcd_valid) begin
          r_pend_val  <= bcd_in;
          r_pend_flag <= 1'b1;
        end
        r_loaded <= 1'b0;
      end

      // Outputs lag the scan index by one cycle.
      r_an  <= w_an_ah ^ AN_OFF;
      r_seg <= (w_dark ? 7'h00 : w_seg_dec) ^ SEG_OFF;
      r_dp  <= ACTIVE_LOW;
    end
  end

  assign an     = r_an;
  assign seg    = r_seg;
  assign dp     = r_dp;
  assign loaded = r_loaded;

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd_in = 12'h000;
  logic        bcd_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        loaded;

  int pass_cnt = 0;
  int total_cnt = 0;

  bcd_scan_display #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .loaded    (loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d > 4'd9) return 7'h40;
    return t[d];
  endfunction

  // Outputs visible after the kk-th rising edge since reset release:
  // the edge shows the digit slot that was current before it.
  function automatic logic [10:0] model_out(input int kk, input logic [11:0] d, input logic blz);
    int slot;
    int hund, tens, ones, digit;
    bit dark;
    logic [3:0] a;
    logic [6:0] s;
    slot = ((kk - 1) / DIV) % 4;
    hund = int'(d[11:8]);
    tens = int'(d[7:4]);
    ones = int'(d[3:0]);
    digit = (slot == 0) ? ones : (slot == 1) ? tens : hund;
    dark = (slot == 3) ||
           (slot == 2 && blz && hund == 0) ||
           (slot == 1 && blz && hund == 0 && tens == 0);
    a = dark ? 4'h0 : 4'(1 << slot);
    s = dark ? 7'h00 : glyph(4'(digit));
    return {~a, ~s};
  endfunction

  int          k = 0;
  logic [11:0] m_disp = 12'h000;
  logic [11:0] m_pend = 12'h000;
  bit          m_has_pend = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_loaded = 1'b0;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k          <= 0;
      m_disp     <= 12'h000;
      m_pend     <= 12'h000;
      m_has_pend <= 1'b0;
      e_an       <= 4'hF;
      e_seg      <= 7'h7F;
      e_dp       <= 1'b1;
      e_loaded   <= 1'b0;
      m_live     <= 1'b1;
    end else begin
      k <= k + 1;
      {e_an, e_seg} <= model_out(k + 1, m_disp, blank_lz);
      e_dp <= 1'b1;
      if ((k + 1) % FRAME == 0) begin
        e_loaded <= bcd_valid || m_has_pend;
        if (bcd_valid) m_disp <= bcd_in;
        else if (m_has_pend) m_disp <= m_pend;
        m_has_pend <= 1'b0;
      end else begin
        e_loaded <= 1'b0;
        if (bcd_valid) begin
          m_pend     <= bcd_in;
          m_has_pend <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model an", {28'd0, an}, {28'd0, e_an});
      chk("model seg", {25'd0, seg}, {25'd0, e_seg});
      chk("model dp", {31'd0, dp}, {31'd0, e_dp});
      chk("model loaded", {31'd0, loaded}, {31'd0, e_loaded});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Return at the negedge where digit 0 of a new frame is on the outputs.
  task automatic sync_frame();
    bit found = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      if (k % FRAME == 1) found = 1'b1;
    end
    if (!found) begin
      total_cnt++;
      $display("FAIL sync_frame: got no frame start, expected one within %0d cycles", 3 * FRAME);
    end
  endtask

  task automatic pulse(input logic [11:0] v);
    bcd_in    = v;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask

  task automatic count_loaded(input string nm, input int n, input int exp);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (loaded === 1'b1) c++;
    end
    chk(nm, 32'(c), 32'(exp));
  endtask

  // Check digits 0..2 of the current frame; packed low digit first.
  task automatic check_frame(input string nm, input logic [11:0] exp_an, input logic [20:0] exp_seg);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s an%0d", nm, d), {28'd0, an}, {28'd0, exp_an[d*4 +: 4]});
      chk($sformatf("%s seg%0d", nm, d), {25'd0, seg}, {25'd0, exp_seg[d*7 +: 7]});
      if (d < 2) tick_n(DIV);
    end
  endtask

  task automatic show(input string nm, input logic [11:0] v, input logic blz,
                      input logic [11:0] exp_an, input logic [20:0] exp_seg);
    blank_lz = blz;
    sync_frame();
    tick_n(1);
    pulse(v);
    sync_frame();
    check_frame(nm, exp_an, exp_seg);
    $display("show %s: value %03h blank_lz=%0d", nm, v, blz);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // 1. reset and first frame
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst an", {28'd0, an}, 32'hF);
      chk("rst seg", {25'd0, seg}, 32'h7F);
      chk("rst loaded", {31'd0, loaded}, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first an", {28'd0, an}, 32'b1110);
    chk("first seg", {25'd0, seg}, 32'h40);
    tick_n(DIV);
    chk("scan an1", {28'd0, an}, 32'b1101);
    tick_n(DIV);
    chk("scan an2", {28'd0, an}, 32'b1011);
    tick_n(DIV);
    chk("scan an3", {28'd0, an}, 32'b1111);
    chk("scan seg3", {25'd0, seg}, 32'h7F);
    $display("reset/first frame done");

    // 2. frame-aligned load of 225
    pulse(12'h225);
    count_loaded("load225 pulses", 20, 1);
    sync_frame();
    check_frame("val225", {4'b1011, 4'b1101, 4'b1110}, {7'h24, 7'h24, 7'h12});
    $display("load 225 done");

    // 3. last writer wins, then boundary bypass
    sync_frame();
    pulse(12'h012);
    tick_n(2);
    pulse(12'h049);
    sync_frame();
    check_frame("val049", {4'b1011, 4'b1101, 4'b1110}, {7'h40, 7'h19, 7'h10});
    $display("last-writer 012->049 done");

    pulse(12'h300);
    begin
      bit found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
        if (k % FRAME == FRAME - 1) found = 1'b1;
        else @(negedge clk);
      end
      if (!found) begin
        total_cnt++;
        $display("FAIL bypass sync: got no boundary slot, expected one");
      end
    end
    bcd_in    = 12'h100;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
    chk("bypass loaded", {31'd0, loaded}, 32'h1);
    count_loaded("bypass clears pend", 20, 0);
    sync_frame();
    check_frame("val100", {4'b1011, 4'b1101, 4'b1110}, {7'h79, 7'h40, 7'h40});
    $display("bypass 100 done");

    // 4. leading-zero blanking
    show("lz007", 12'h007, 1'b1, {4'b1111, 4'b1111, 4'b1110}, {7'h7F, 7'h7F, 7'h78});
    show("lz040", 12'h040, 1'b1, {4'b1111, 4'b1101, 4'b1110}, {7'h7F, 7'h19, 7'h40});
    show("lz000", 12'h000, 1'b1, {4'b1111, 4'b1111, 4'b1110}, {7'h7F, 7'h7F, 7'h40});
    show("nolz007", 12'h007, 1'b0, {4'b1011, 4'b1101, 4'b1110}, {7'h40, 7'h40, 7'h78});

    // 5. invalid nibble stops blanking and shows a dash
    show("dash0A3", 12'h0A3, 1'b1, {4'b1111, 4'b1101, 4'b1110}, {7'h7F, 7'h3F, 7'h30});

    // 6. reset mid-operation discards pending value
    blank_lz = 1'b0;
    sync_frame();
    pulse(12'h081);
    tick_n(3);
    rst = 1'b1;
    tick_n(2);
    rst = 1'b0;
    count_loaded("rst discards pend", 2 * FRAME + 4, 0);
    sync_frame();
    check_frame("after rst", {4'b1011, 4'b1101, 4'b1110}, {7'h40, 7'h40, 7'h40});
    $display("reset mid-operation done");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
